// File: rtl/writeback_unit.sv
// Register-file write port arbiter: ALU results take priority over a small FIFO of
// long-latency results, with a per-register pending scoreboard for issue stalls.
module writeback_unit #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      lsu_valid,
  output logic                      lsu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]     lsu_data,
  input  logic                      issue_long,
  input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] chk_rs2,
  output logic                      stall,
  output logic [REG_ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      reg_write
);

  localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned NUM_REGS = 1 << REG_ADDR_WIDTH;

  logic [REG_ADDR_WIDTH-1:0] fifo_rd_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [CNT_W-1:0]          count_q;
  logic [NUM_REGS-1:0]       pending_q;
  logic [NUM_REGS-1:0]       pending_d;
  logic                      push_c;
  logic                      pop_c;

  // Ready and stall depend only on registered state and the issue-stage indices.
  assign lsu_ready = (count_q != CNT_W'(FIFO_DEPTH));
  assign stall     = pending_q[chk_rs1] | pending_q[chk_rs2] | pending_q[issue_rd];

  // Results destined for x0 are accepted but never stored.
  assign push_c = lsu_valid && lsu_ready && (lsu_rd != '0);
  assign pop_c  = !alu_valid && (count_q != '0);

  // Buffer storage carries no reset; occupancy is tracked by the count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      fifo_rd_q[wr_ptr_q]   <= lsu_rd;
      fifo_data_q[wr_ptr_q] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Clear on committed write, then set from issue so a same-edge set wins.
  always_comb begin
    pending_d = pending_q;
    if (reg_write) pending_d[rd_addr] = 1'b0;
    if (issue_long && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Write port: ALU has priority, otherwise drain the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write <= 1'b0;
      rd_addr   <= '0;
      rd_data   <= '0;
    end else if (alu_valid) begin
      reg_write <= (alu_rd != '0);
      rd_addr   <= alu_rd;
      rd_data   <= alu_data;
    end else if (pop_c) begin
      reg_write <= 1'b1;
      rd_addr   <= fifo_rd_q[rd_ptr_q];
      rd_data   <= fifo_data_q[rd_ptr_q];
    end else begin
      reg_write <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector bench for writeback_unit: ALU path, scoreboard timing, FIFO
// arbitration/wrap, x0 discard, same-edge set/clear and reset mid-drain.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_long;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        stall;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_long(issue_long), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .stall(stall),
    .rd_addr(rd_addr), .rd_data(rd_data), .reg_write(reg_write)
  );

  typedef struct {
    logic        rst;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        il;  logic [4:0] ird;
    logic [4:0]  rs1; logic [4:0] rs2;
    logic        e_stall; logic e_ready; logic e_we; logic e_chk;
    logic [4:0]  e_addr;  logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic av, logic [4:0] ard, logic [31:0] ad,
                              logic lv, logic [4:0] lrd, logic [31:0] ld,
                              logic il, logic [4:0] ird, logic [4:0] rs1, logic [4:0] rs2,
                              logic e_stall, logic e_ready, logic e_we, logic e_chk,
                              logic [4:0] e_addr, logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld; v.il = il; v.ird = ird;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e_stall = e_stall; v.e_ready = e_ready; v.e_we = e_we; v.e_chk = e_chk;
    v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Inputs change at negedge; comb outputs checked before the edge, registers after.
  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    rst_n = !v.rst;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    issue_long = v.il; issue_rd = v.ird;
    chk_rs1 = v.rs1; chk_rs2 = v.rs2;
    #1;
    chk("stall", idx, 32'(stall), 32'(v.e_stall));
    chk("lsu_ready", idx, 32'(lsu_ready), 32'(v.e_ready));
    @(posedge clk);
    #1;
    chk("reg_write", idx, 32'(reg_write), 32'(v.e_we));
    if (v.e_chk) begin
      chk("rd_addr", idx, 32'(rd_addr), 32'(v.e_addr));
      chk("rd_data", idx, rd_data, v.e_data);
    end
  endtask

  initial begin
    // Reset held with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alu_valid = 1'($urandom); alu_rd = 5'($urandom); alu_data = $urandom;
      lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom;
      issue_long = 1'($urandom); issue_rd = 5'($urandom);
      chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom);
      #1;
      chk("rst_stall", i, 32'(stall), 32'd0);
      chk("rst_ready", i, 32'(lsu_ready), 32'd1);
      @(posedge clk);
      #1;
      chk("rst_we", i, 32'(reg_write), 32'd0);
      chk("rst_addr", i, 32'(rd_addr), 32'd0);
      chk("rst_data", i, rd_data, 32'd0);
    end

    //                rst av ard  ad            lv lrd  ld            il ird rs1 rs2  stl rdy we chk addr data
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 0, 0, 0,  0));
    // ALU path
    vecs.push_back(mk(0, 1, 5,  32'hDEADBEEF, 0, 0,  0,            0, 0,  0,  0,   0, 1, 1, 1, 5,  32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 0,  32'h00001111, 0, 0,  0,            0, 0,  0,  0,   0, 1, 0, 0, 0,  0));
    // Long op on x7: issue, push, pop, commit, stall release
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            1, 7,  7,  0,   0, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  7,  0,   1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 7,  32'h12345678, 0, 0,  0,  7,   1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  7,  0,   1, 1, 1, 1, 7,  32'h12345678));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  7,  0,   1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  7,  0,   0, 1, 0, 0, 0,  0));
    // ALU starves FIFO: 4 accepted, 5th refused, then drain in order
    vecs.push_back(mk(0, 1, 1,  32'hA1,       1, 10, 32'h100,      0, 0,  0,  0,   0, 1, 1, 1, 1,  32'hA1));
    vecs.push_back(mk(0, 1, 2,  32'hA2,       1, 11, 32'h101,      0, 0,  0,  0,   0, 1, 1, 1, 2,  32'hA2));
    vecs.push_back(mk(0, 1, 3,  32'hA3,       1, 12, 32'h102,      0, 0,  0,  0,   0, 1, 1, 1, 3,  32'hA3));
    vecs.push_back(mk(0, 1, 4,  32'hA4,       1, 13, 32'h103,      0, 0,  0,  0,   0, 1, 1, 1, 4,  32'hA4));
    vecs.push_back(mk(0, 1, 5,  32'hA5,       1, 14, 32'h104,      0, 0,  0,  0,   0, 0, 1, 1, 5,  32'hA5));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 0, 1, 1, 10, 32'h100));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 1, 1, 11, 32'h101));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 1, 1, 12, 32'h102));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 1, 1, 13, 32'h103));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 0, 0, 0,  0));
    // Count 2 with simultaneous push/pop, pointers wrapping
    vecs.push_back(mk(0, 1, 1,  32'hB1,       1, 20, 32'h200,      0, 0,  0,  0,   0, 1, 1, 1, 1,  32'hB1));
    vecs.push_back(mk(0, 1, 2,  32'hB2,       1, 21, 32'h201,      0, 0,  0,  0,   0, 1, 1, 1, 2,  32'hB2));
    vecs.push_back(mk(0, 0, 0,  0,            1, 22, 32'h202,      0, 0,  0,  0,   0, 1, 1, 1, 20, 32'h200));
    vecs.push_back(mk(0, 0, 0,  0,            1, 23, 32'h203,      0, 0,  0,  0,   0, 1, 1, 1, 21, 32'h201));
    vecs.push_back(mk(0, 0, 0,  0,            1, 24, 32'h204,      0, 0,  0,  0,   0, 1, 1, 1, 22, 32'h202));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 1, 1, 23, 32'h203));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 1, 1, 24, 32'h204));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 0, 0, 0,  0));
    // Push to x0 is accepted and discarded
    vecs.push_back(mk(0, 0, 0,  0,            1, 0,  32'h999,      0, 0,  0,  0,   0, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 0, 0, 0,  0));
    // Same-edge clear and set of x3: set wins
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            1, 3,  0,  0,   0, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            1, 3,  32'h333,      0, 0,  3,  0,   1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  3,  0,   1, 1, 1, 1, 3,  32'h333));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            1, 3,  3,  0,   1, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  3,  0,   1, 1, 0, 0, 0,  0));
    // Queue 3 entries and pend x9 (x3 already pending), then reset mid-drain
    vecs.push_back(mk(0, 1, 1,  32'hC1,       1, 15, 32'h150,      1, 9,  0,  0,   0, 1, 1, 1, 1,  32'hC1));
    vecs.push_back(mk(0, 1, 2,  32'hC2,       1, 16, 32'h160,      0, 0,  9,  3,   1, 1, 1, 1, 2,  32'hC2));
    vecs.push_back(mk(0, 1, 4,  32'hC4,       1, 17, 32'h170,      0, 0,  0,  0,   0, 1, 1, 1, 4,  32'hC4));
    vecs.push_back(mk(1, 0, 0,  0,            0, 0,  0,            0, 0,  3,  9,   0, 1, 0, 1, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  3,  9,   0, 1, 0, 1, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  9,  3,   0, 1, 0, 0, 0,  0));
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0,            0, 0,  0,  0,   0, 1, 0, 0, 0,  0));

    for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

- Sits between the execute back-end and the register file.
- Drives the register file write port (`rd_addr`, `rd_data`, `reg_write`), merging single-cycle ALU results with buffered long-latency (LSU/multiply) results.
- Keeps a per-register pending scoreboard so issue logic stalls on operands that an in-flight long-latency operation will write.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register data width
- `REG_ADDR_WIDTH`, 5, register index width (32 registers, x0 hardwired zero)
- `FIFO_DEPTH`, 4, long-latency result buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `alu_valid`  in  1  ALU result present this cycle (no backpressure)
- `alu_rd`  in  REG_ADDR_WIDTH  ALU destination
- `alu_data`  in  DATA_WIDTH  ALU result
- `lsu_valid`  in  1  long-latency result offered
- `lsu_ready`  out  1  buffer can accept; transfer when `lsu_valid && lsu_ready`
- `lsu_rd`  in  REG_ADDR_WIDTH  long-latency destination
- `lsu_data`  in  DATA_WIDTH  long-latency result
- `issue_long`  in  1  a long-latency op issues this cycle (mark `issue_rd` pending)
- `issue_rd`  in  REG_ADDR_WIDTH  destination of issuing op
- `chk_rs1`, `chk_rs2`  in  REG_ADDR_WIDTH  operands of the instruction in issue
- `stall`  out  1  combinational: `chk_rs1`, `chk_rs2` or `issue_rd` is pending
- `rd_addr`  out  REG_ADDR_WIDTH  register file write address (registered)
- `rd_data`  out  DATA_WIDTH  register file write data (registered)
- `reg_write`  out  1  register file write enable (registered)

## Operation
- Reset (async, `rst_n` low):
  - FIFO emptied (pointers and count 0).
  - All pending bits 0.
  - `reg_write`=0, `rd_addr`=0, `rd_data`=0.
  - `lsu_ready`=1 and `stall`=0 immediately.
  - Reset mid-operation discards all buffered results.
- FIFO:
  - Circular buffer; read and write pointers wrap modulo `FIFO_DEPTH`.
  - Occupancy count runs 0..`FIFO_DEPTH`.
  - `lsu_ready` = (count != `FIFO_DEPTH`), derived from registered count only.
  - A push with `lsu_rd`==0 is accepted and discarded (not stored).
- Per-cycle write selection:
  - If `alu_valid`: ALU wins. Load `rd_addr`/`rd_data` from the ALU; `reg_write` = (`alu_rd`!=0). No FIFO pop.
  - Else if FIFO non-empty (registered count > 0): pop the head into `rd_addr`/`rd_data`; `reg_write`=1.
  - Else: `reg_write`=0; `rd_addr`/`rd_data` hold their values.
- Push and pop in the same cycle: count unchanged and both pointers advance. A push into an empty FIFO is never popped in that same cycle.
- Scoreboard (one bit per register, bit 0 constant 0):
  - Set: `issue_long && issue_rd!=0` sets `pending[issue_rd]`.
  - Clear: registered `reg_write` high clears `pending[rd_addr]` on the edge at which the register file commits that write. Any instruction issuing after that edge therefore reads the new value.
  - Set and clear of the same register on the same edge: set wins.
  - `stall` = `pending[chk_rs1] | pending[chk_rs2] | pending[issue_rd]`. This also blocks WAW on long ops.
- ALU writes never touch the scoreboard. ALU forwarding is outside this block.

## Timing
- ALU result at cycle N → `reg_write` high during N+1 → register file updated at end of N+1.
- LSU push at cycle N, no ALU activity → popped in N+1 → `reg_write` high during N+2 → pending cleared at end of N+2. `stall` drops in N+3.
- Each consecutive ALU cycle delays a pop by exactly one cycle. Sustained `alu_valid` starves the FIFO; `lsu_ready` falls once FIFO_DEPTH entries are queued.
- FIFO drain rate: one entry per cycle without ALU activity.
- `stall` and `lsu_ready` are combinational from registered state plus `chk_*`/`issue_rd`. There is no combinational path from `lsu_valid` to `lsu_ready`.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `reg_write`=0, `rd_addr`=0, `rd_data`=0, `lsu_ready`=1, `stall`=0; release and check an idle cycle keeps `reg_write`=0.
- ALU path: `alu_valid`, rd=5, data=0xDEADBEEF at cycle N → `reg_write`=1, rd_addr=5, rd_data=0xDEADBEEF in N+1. Same with rd=0 → `reg_write`=0.
- Long op and scoreboard:
  - `issue_long` rd=7 → `stall`=1 for chk_rs1=7 (and for chk_rs2=7).
  - LSU push rd=7, data=0x12345678 → write in push+2.
  - `stall`=0 from push+3.
- Arbitration and full FIFO:
  - `alu_valid` continuously while 5 LSU results are offered → 4 accepted, then `lsu_ready`=0.
  - After ALU stops, 4 writes follow in FIFO order on consecutive cycles.
  - `lsu_ready` returns to 1 the cycle after the first pop.
- Simultaneous events:
  - FIFO at count 2 with a push and pop in the same cycle → count stays 2, and pointer wrap past DEPTH-1 preserves data order.
  - Clear and set of rd=3 on the same edge → `pending[3]` remains 1.
- Reset mid-drain: 3 entries queued and 2 registers pending, assert `rst_n`=0 → no further `reg_write`, `stall`=0, `lsu_ready`=1.
